// File: rtl/cdcsync_pkg.sv
// cdcsync_pkg
// Shared types and helpers for the level-to-event consumer.
//   evt_pol_e : polarity tag stored per queued event (fall / rise)
//   pend_w()  : width of the pending-count output for a given queue depth
package cdcsync_pkg;

    typedef enum logic {
        EVT_FALL = 1'b0,
        EVT_RISE = 1'b1
    } evt_pol_e;

    // The count has to represent 0..depth inclusive, so it needs one bit more
    // than the queue index.
    function automatic int pend_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cdcsync_lvl_evt_if.sv
// cdcsync_lvl_evt_if
// Event delivery bundle between the event queue and destination logic.
//   evt_vld  : head event valid (producer -> consumer)
//   evt_rdy  : consumer accepts the head event (consumer -> producer)
//   evt_pol  : head event polarity, 1 = rise, 0 = fall (producer -> consumer)
//   evt_pend : number of queued events, 0..DEPTH (producer -> consumer)
//
// Handshake: an event transfers at a rising clock edge where evt_vld and
// evt_rdy are both high. evt_rdy with evt_vld low does nothing. While
// evt_vld is high and evt_rdy is low, evt_pol holds its value.
interface cdcsync_lvl_evt_if
    import cdcsync_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int PW = pend_w(DEPTH);

    logic          evt_vld;
    logic          evt_rdy;
    logic          evt_pol;
    logic [PW-1:0] evt_pend;

    modport master (
        output evt_vld,
        output evt_pol,
        output evt_pend,
        input  evt_rdy
    );

    modport slave (
        input  evt_vld,
        input  evt_pol,
        input  evt_pend,
        output evt_rdy
    );

endinterface

// File: rtl/cdcsync_evt_fifo.sv
// cdcsync_evt_fifo
// Queue of polarity-tagged events.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   push_i, pol_i : new event and its polarity
//   pop_i         : consumer accepts head (ignored when empty)
//   vld_o, pol_o  : queue not empty, head polarity (0 when empty)
//   pend_o        : number of queued events
//   drop_o        : push refused because the queue is full and not popping
module cdcsync_evt_fifo
    import cdcsync_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = pend_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  evt_pol_e      pol_i,
    input  logic          pop_i,
    output logic          vld_o,
    output logic          pol_o,
    output logic [PW-1:0] pend_o,
    output logic          drop_o
);
    localparam int AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    evt_pol_e      mem_q [DEPTH];

    logic empty, full, do_pop, do_push;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    // A pop on the same edge frees the slot the push lands in.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= EVT_FALL;
        end else begin
            if (do_push) mem_q[wptr_q[AW-1:0]] <= pol_i;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign vld_o  = !empty;
    assign pol_o  = !empty && (mem_q[rptr_q[AW-1:0]] == EVT_RISE);
    assign pend_o = wptr_q - rptr_q;

endmodule

// File: rtl/cdcsync_lvl_evt.sv
// cdcsync_lvl_evt
// Destination-domain consumer of a synchronized level. The level is filtered
// for a minimum stable time, each filtered transition is queued as a
// polarity-tagged event and handed out over a valid/ready interface.
//   des_clk   : destination clock
//   des_rstn  : synchronous active-low reset
//   des_lvl   : synchronized level input
//   lvl_q     : filtered level
//   ovf       : sticky, set when an event was dropped on a full queue
//   ovf_clr   : clears ovf (a drop in the same cycle wins)
//   evt       : event interface (evt_vld, evt_rdy, evt_pol, evt_pend)
module cdcsync_lvl_evt
    import cdcsync_pkg::*;
#(
    parameter int   FILT_CYC = 2,
    parameter int   DEPTH    = 4,
    parameter logic RST_LVL  = 1'b0
) (
    input  logic                      des_clk,
    input  logic                      des_rstn,
    input  logic                      des_lvl,
    output logic                      lvl_q,
    output logic                      ovf,
    input  logic                      ovf_clr,
    cdcsync_lvl_evt_if.master         evt
);
    localparam int       PW       = pend_w(DEPTH);
    localparam int       CW       = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam [CW-1:0]  MCNT_MAX = CW'(FILT_CYC - 1);

    logic          filt_q, filt_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic          ovf_q, ovf_d;
    logic          push;
    evt_pol_e      push_pol;
    logic          drop;
    logic [PW-1:0] pend;

    // mcnt counts consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the count, so short glitches vanish.
    always_comb begin
        filt_d   = filt_q;
        mcnt_d   = mcnt_q;
        push     = 1'b0;
        push_pol = des_lvl ? EVT_RISE : EVT_FALL;
        if (des_lvl == filt_q) begin
            mcnt_d = '0;
        end else if (mcnt_q == MCNT_MAX) begin
            filt_d = des_lvl;
            mcnt_d = '0;
            push   = 1'b1;
        end else begin
            mcnt_d = mcnt_q + CW'(1);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge des_clk) begin
        if (!des_rstn) begin
            filt_q <= RST_LVL;
            mcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            filt_q <= filt_d;
            mcnt_q <= mcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    cdcsync_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (des_clk),
        .rstn_i (des_rstn),
        .push_i (push),
        .pol_i  (push_pol),
        .pop_i  (evt.evt_rdy),
        .vld_o  (evt.evt_vld),
        .pol_o  (evt.evt_pol),
        .pend_o (pend),
        .drop_o (drop)
    );

    assign evt.evt_pend = pend;
    assign lvl_q        = filt_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_cdcsync_lvl_evt.sv
// tb_cdcsync_lvl_evt
// Self-checking bench for cdcsync_lvl_evt with FILT_CYC=2, DEPTH=4, RST_LVL=0.
// Directed scenarios compare against hand-derived constants; the random
// scenario compares against a queue-based reference model.
module tb_cdcsync_lvl_evt;
  localparam int   FILT_CYC = 2;
  localparam int   DEPTH    = 4;
  localparam logic RST_LVL  = 1'b0;

  logic des_clk = 1'b0;
  logic des_rstn;
  logic des_lvl;
  logic ovf_clr;
  logic lvl_q;
  logic ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  cdcsync_lvl_evt_if #(.DEPTH(DEPTH)) evt_if ();

  cdcsync_lvl_evt #(
    .FILT_CYC (FILT_CYC),
    .DEPTH    (DEPTH),
    .RST_LVL  (RST_LVL)
  ) dut (
    .des_clk  (des_clk),
    .des_rstn (des_rstn),
    .des_lvl  (des_lvl),
    .lvl_q    (lvl_q),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .evt      (evt_if)
  );

  // ---------------- clock ----------------
  always #5 des_clk = ~des_clk;

  // ---------------- reference model ----------------
  // m_run: how many consecutive samples have disagreed with the filtered
  // level; the level follows once that reaches FILT_CYC.
  logic       m_lvl = RST_LVL;
  int         m_run = 0;
  logic [0:0] exp_q[$];
  logic       m_ovf = 1'b0;

  task automatic model_edge();
    bit pop_now, push_now, full_now;
    if (!des_rstn) begin
      m_lvl = RST_LVL;
      m_run = 0;
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop_now  = (exp_q.size() > 0) && evt_if.evt_rdy;
      full_now = (exp_q.size() == DEPTH);
      push_now = 1'b0;
      m_run = (des_lvl == m_lvl) ? 0 : m_run + 1;
      if (m_run == FILT_CYC) begin
        push_now = 1'b1;
        m_lvl    = des_lvl;
        m_run    = 0;
      end
      if (pop_now) void'(exp_q.pop_front());
      if (push_now && full_now && !pop_now) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (push_now && (!full_now || pop_now)) exp_q.push_back(m_lvl);
    end
  endtask

  // One clock: inputs already driven, DUT and model see the same edge,
  // outputs are sampled 1ns later.
  task automatic step();
    @(posedge des_clk);
    model_edge();
    #1;
  endtask

  // Packed observation {lvl_q, evt_vld, evt_pol, evt_pend[2:0], ovf}
  function automatic logic [6:0] obs();
    return {lvl_q, evt_if.evt_vld, evt_if.evt_pol, evt_if.evt_pend, ovf};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [6:0] o;
    des_rstn = 1'b0; des_lvl = 1'b0; ovf_clr = 1'b0; evt_if.evt_rdy = 1'b0;
    step(); step();
    o = obs(); n_cmp++;
    if (o !== 7'b0_0_0_000_0) begin n_fail++; $display("FAIL reset_state: got %b exp %b", o, 7'b0); end
    des_rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      o = obs(); n_cmp++;
      if (o !== 7'b0_0_0_000_0) begin n_fail++; $display("FAIL idle_low cyc %0d: got %b exp %b", i, o, 7'b0); end
    end
  endtask

  task automatic test_rise_fall();
    logic [6:0] o;
    logic [6:0] exp_v [6];
    exp_v = '{7'b0_0_0_000_0, 7'b1_1_1_001_0, 7'b1_0_0_000_0,
              7'b1_0_0_000_0, 7'b0_1_0_001_0, 7'b0_0_0_000_0};
    evt_if.evt_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) des_lvl = 1'b1;
      if (i == 3) des_lvl = 1'b0;
      step();
      o = obs(); n_cmp++;
      if (o !== exp_v[i]) begin n_fail++; $display("FAIL rise_fall step %0d: got %b exp %b", i, o, exp_v[i]); end
    end
    evt_if.evt_rdy = 1'b0;
  endtask

  task automatic test_glitch();
    logic [6:0] o;
    logic [6:0] exp_v [6];
    // one-cycle pulse: filtered away
    evt_if.evt_rdy = 1'b1;
    des_lvl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) des_lvl = 1'b0;
      o = obs(); n_cmp++;
      if (o !== 7'b0_0_0_000_0) begin n_fail++; $display("FAIL glitch1 step %0d: got %b exp %b", i, o, 7'b0); end
    end
    // two-cycle pulse: rise event, then fall event two cycles after return low
    evt_if.evt_rdy = 1'b0;
    exp_v = '{7'b0_0_0_000_0, 7'b1_1_1_001_0, 7'b1_1_1_001_0,
              7'b0_1_1_010_0, 7'b0_1_0_001_0, 7'b0_0_0_000_0};
    des_lvl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) des_lvl = 1'b0;
      if (i == 4) evt_if.evt_rdy = 1'b1;
      step();
      o = obs(); n_cmp++;
      if (o !== exp_v[i]) begin n_fail++; $display("FAIL glitch2 step %0d: got %b exp %b", i, o, exp_v[i]); end
    end
    evt_if.evt_rdy = 1'b0;
  endtask

  task automatic test_overflow();
    logic [6:0] o, e;
    logic drain_pol [4];
    drain_pol = '{1'b1, 1'b0, 1'b1, 1'b0};
    evt_if.evt_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      des_lvl = ~des_lvl;
      step(); step();
      e = {logic'(i % 2 == 0), 1'b1, 1'b1, 3'((i < 4) ? i + 1 : 4), logic'(i == 4)};
      o = obs(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL ovf_fill %0d: got %b exp %b", i, o, e); end
    end
    evt_if.evt_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (evt_if.evt_vld !== 1'b1 || evt_if.evt_pol !== drain_pol[k]) begin
        n_fail++; $display("FAIL ovf_drain %0d: got vld=%b pol=%b exp vld=1 pol=%b", k, evt_if.evt_vld, evt_if.evt_pol, drain_pol[k]);
      end
      step();
    end
    evt_if.evt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      o = obs(); n_cmp++;
      if (o !== 7'b1_0_0_000_1) begin n_fail++; $display("FAIL ovf_sticky %0d: got %b exp %b", i, o, 7'b1_0_0_000_1); end
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    o = obs(); n_cmp++;
    if (o !== 7'b1_0_0_000_0) begin n_fail++; $display("FAIL ovf_clr: got %b exp %b", o, 7'b1_0_0_000_0); end
  endtask

  task automatic test_full_push_pop();
    logic [6:0] o;
    logic drain_pol [4];
    drain_pol = '{1'b1, 1'b0, 1'b1, 1'b0};
    evt_if.evt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      des_lvl = ~des_lvl;
      step(); step();
    end
    o = obs(); n_cmp++;
    if (o !== 7'b1_1_0_100_0) begin n_fail++; $display("FAIL full_fill: got %b exp %b", o, 7'b1_1_0_100_0); end
    des_lvl = 1'b0;
    step();
    evt_if.evt_rdy = 1'b1;
    step();
    o = obs(); n_cmp++;
    if (o !== 7'b0_1_1_100_0) begin n_fail++; $display("FAIL full_push_pop: got %b exp %b", o, 7'b0_1_1_100_0); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (evt_if.evt_vld !== 1'b1 || evt_if.evt_pol !== drain_pol[k]) begin
        n_fail++; $display("FAIL full_drain %0d: got vld=%b pol=%b exp vld=1 pol=%b", k, evt_if.evt_vld, evt_if.evt_pol, drain_pol[k]);
      end
      step();
    end
    o = obs(); n_cmp++;
    if (o !== 7'b0_0_0_000_0) begin n_fail++; $display("FAIL full_empty: got %b exp %b", o, 7'b0); end
    evt_if.evt_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    evt_if.evt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      des_lvl = ~des_lvl;
      step(); step();
    end
    o = obs(); n_cmp++;
    if (o !== 7'b1_1_1_011_0) begin n_fail++; $display("FAIL mid_fill: got %b exp %b", o, 7'b1_1_1_011_0); end
    des_rstn = 1'b0;
    step();
    o = obs(); n_cmp++;
    if (o !== 7'b0_0_0_000_0) begin n_fail++; $display("FAIL mid_reset: got %b exp %b", o, 7'b0); end
    des_rstn = 1'b1;
    step();
    o = obs(); n_cmp++;
    if (o !== 7'b0_0_0_000_0) begin n_fail++; $display("FAIL post_rst_wait: got %b exp %b", o, 7'b0); end
    step();
    o = obs(); n_cmp++;
    if (o !== 7'b1_1_1_001_0) begin n_fail++; $display("FAIL post_rst_evt: got %b exp %b", o, 7'b1_1_1_001_0); end
    evt_if.evt_rdy = 1'b1;
    step();
    evt_if.evt_rdy = 1'b0;
    o = obs(); n_cmp++;
    if (o !== 7'b1_0_0_000_0) begin n_fail++; $display("FAIL post_rst_pop: got %b exp %b", o, 7'b1_0_0_000_0); end
  endtask

  task automatic test_random();
    logic       e_pol;
    logic [2:0] e_pend;
    des_rstn = 1'b0;
    step();
    des_rstn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      des_lvl        = ($urandom_range(0, 3) == 0) ? ~des_lvl : des_lvl;
      evt_if.evt_rdy = ($urandom_range(0, 2) == 0);
      ovf_clr        = ($urandom_range(0, 19) == 0);
      des_rstn       = ($urandom_range(0, 299) != 0);
      step();
      e_pend = 3'(exp_q.size());
      e_pol  = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (lvl_q !== m_lvl) begin n_fail++; $display("FAIL rnd_lvl cyc %0d: got %b exp %b", c, lvl_q, m_lvl); end
      n_cmp++;
      if (evt_if.evt_vld !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_vld cyc %0d: got %b exp %b", c, evt_if.evt_vld, exp_q.size() > 0); end
      n_cmp++;
      if (evt_if.evt_pol !== e_pol) begin n_fail++; $display("FAIL rnd_pol cyc %0d: got %b exp %b", c, evt_if.evt_pol, e_pol); end
      n_cmp++;
      if (evt_if.evt_pend !== e_pend) begin n_fail++; $display("FAIL rnd_pend cyc %0d: got %0d exp %0d", c, evt_if.evt_pend, e_pend); end
      n_cmp++;
      if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d: got %b exp %b", c, ovf, m_ovf); end
    end
    des_rstn = 1'b1; ovf_clr = 1'b0; evt_if.evt_rdy = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    des_rstn = 1'b0; des_lvl = 1'b0; ovf_clr = 1'b0; evt_if.evt_rdy = 1'b0;
    test_reset();
    test_rise_fall();
    test_glitch();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
